// File: rtl/pe_inst_sequencer.sv
// Broadcasts the PE instruction program (SET, LOAD_IFMAP/LOAD_WGHT/CONV per pass, optional ACC)
// with a per-PE valid/ready handshake. Optional macro PE_SEQ_STALL_CNT_EN adds o_stall_cnt.
module pe_inst_sequencer #(
    parameter int NUM_PE             = 4,
    parameter int CONV_INFO_BITWIDTH = 9,
    parameter int PASS_BITWIDTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic [CONV_INFO_BITWIDTH-1:0] i_conv_info,
    input  logic [PASS_BITWIDTH-1:0]      i_num_pass,
    input  logic                          i_acc_en,
    output logic [2:0]                    o_opcode,
    output logic [CONV_INFO_BITWIDTH-1:0] o_conv_info,
    output logic [NUM_PE-1:0]             o_inst_valid,
    input  logic [NUM_PE-1:0]             i_inst_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err,
`ifdef PE_SEQ_STALL_CNT_EN
    output logic [15:0]                   o_stall_cnt,
`endif
    output logic [PASS_BITWIDTH-1:0]      o_pass_idx
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_LIF  = 3'b010;
    localparam logic [2:0] OP_LWG  = 3'b011;
    localparam logic [2:0] OP_CONV = 3'b100;
    localparam logic [2:0] OP_ACC  = 3'b101;
    localparam logic [NUM_PE-1:0] ALL_PE = {NUM_PE{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                          state_q;
    logic [2:0]                      opcode_q;
    logic [NUM_PE-1:0]               valid_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            err_q;
    logic [PASS_BITWIDTH-1:0]        pass_q;
    logic [PASS_BITWIDTH-1:0]        num_pass_q;
    logic [CONV_INFO_BITWIDTH-1:0]   conv_q;
    logic                            acc_en_q;
    logic                            drain_min_q;

    logic [NUM_PE-1:0]               pend_d;
    logic                            retire_d;
    logic                            last_pass_d;
    logic                            cfg_bad_d;

    // A bit stays pending until its own PE handshakes; the instruction retires when none remain.
    assign pend_d      = valid_q & ~i_inst_ready;
    assign retire_d    = (state_q == S_ISSUE) && (pend_d == '0);
    assign last_pass_d = (pass_q == num_pass_q - PASS_BITWIDTH'(1));
    assign cfg_bad_d   = (i_conv_info[8:6] == 3'd0) || (i_conv_info[5:3] == 3'd0) ||
                         (i_conv_info[2:0] == 3'd0) || (i_num_pass == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            opcode_q    <= OP_NOP;
            valid_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pass_q      <= '0;
            num_pass_q  <= '0;
            conv_q      <= '0;
            acc_en_q    <= 1'b0;
            drain_min_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (cfg_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            conv_q     <= i_conv_info;
                            num_pass_q <= i_num_pass;
                            acc_en_q   <= i_acc_en;
                            busy_q     <= 1'b1;
                            pass_q     <= '0;
                            opcode_q   <= OP_SET;
                            valid_q    <= ALL_PE;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    valid_q <= pend_d;
                    if (retire_d) begin
                        valid_q <= ALL_PE;
                        case (opcode_q)
                            OP_SET: opcode_q <= OP_LIF;
                            OP_LIF: opcode_q <= OP_LWG;
                            OP_LWG: opcode_q <= OP_CONV;
                            OP_CONV: begin
                                if (!last_pass_d) begin
                                    pass_q   <= pass_q + PASS_BITWIDTH'(1);
                                    opcode_q <= OP_LIF;
                                end else if (acc_en_q) begin
                                    opcode_q <= OP_ACC;
                                end else begin
                                    valid_q     <= '0;
                                    drain_min_q <= 1'b1;
                                    state_q     <= S_DRAIN;
                                end
                            end
                            default: begin
                                valid_q     <= '0;
                                drain_min_q <= 1'b1;
                                state_q     <= S_DRAIN;
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    // First drain cycle is spent unconditionally so a ready held through the last accept is not mistaken for idle.
                    if (drain_min_q) begin
                        drain_min_q <= 1'b0;
                    end else if (i_inst_ready == ALL_PE) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        opcode_q <= OP_NOP;
                        pass_q   <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && i_start && !cfg_bad_d) begin
            stall_q <= '0;
        end else if ((pend_d != '0) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

    assign o_opcode     = opcode_q;
    assign o_conv_info  = conv_q;
    assign o_inst_valid = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_pass_idx   = pass_q;

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Scoreboard bench for pe_inst_sequencer: per-PE expected instruction queues built from the
// program rules, popped by a monitor on every handshake; done/err tokens checked likewise.
module tb_pe_inst_sequencer;
    localparam int NP = 4;
    localparam int CW = 9;
    localparam int PW = 8;
    localparam logic [2:0] SET = 3'd1, LIF = 3'd2, LWG = 3'd3, CONV = 3'd4, ACC = 3'd5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] conv_in = '0;
    logic [PW-1:0] np_in = '0;
    logic          acc_in = 1'b0;
    logic [NP-1:0] ready = '1;
    logic [2:0]    opcode;
    logic [CW-1:0] conv_out;
    logic [NP-1:0] valid;
    logic          busy, done, err;
    logic [PW-1:0] pass_idx;
`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    pe_inst_sequencer #(.NUM_PE(NP), .CONV_INFO_BITWIDTH(CW), .PASS_BITWIDTH(PW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_conv_info(conv_in),
        .i_num_pass(np_in), .i_acc_en(acc_in), .o_opcode(opcode), .o_conv_info(conv_out),
        .o_inst_valid(valid), .i_inst_ready(ready), .o_busy(busy), .o_done(done), .o_err(err),
`ifdef PE_SEQ_STALL_CNT_EN
        .o_stall_cnt(stall_cnt),
`endif
        .o_pass_idx(pass_idx)
    );

    int vec = 0;
    int mis = 0;
    logic [19:0] expq [NP][$];
    int done_exp = 0;
    int err_exp = 0;
    int mode = 0;
    int stall_n = 0;
    int drop_n = 0;
    int lw_hold = 0;
    logic conv_retired = 1'b0;
    logic prev_ok = 1'b0;
    logic [NP-1:0] prev_valid, prev_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            mis++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        vec++;
        mis++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference program: SET, then LIF/LWG/CONV per pass, ACC (at last pass index) if enabled.
    task automatic push_prog(input logic [CW-1:0] ci, input logic [PW-1:0] n, input logic acc);
        for (int i = 0; i < NP; i++) begin
            expq[i].push_back({ci, 8'd0, SET});
            for (int p = 0; p < int'(n); p++) begin
                expq[i].push_back({ci, 8'(p), LIF});
                expq[i].push_back({ci, 8'(p), LWG});
                expq[i].push_back({ci, 8'(p), CONV});
            end
            if (acc) expq[i].push_back({ci, 8'(int'(n) - 1), ACC});
        end
    endtask

    // Monitor: checks every per-PE accept, valid stability, done and err pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (valid[i] && ready[i]) begin
                    if (expq[i].size() == 0) fail_now($sformatf("unexpected_inst pe%0d op%0d", i, opcode));
                    else chk($sformatf("inst_pe%0d", i), {12'd0, conv_out, pass_idx, opcode}, {12'd0, expq[i].pop_front()});
                end
                if (prev_ok && prev_valid[i] && !prev_ready[i]) chk("valid_held", 32'(valid[i]), 32'd1);
            end
            if (valid != '0 && opcode == CONV && (valid & ~ready) == '0) conv_retired = 1'b1;
            if (mode == 2 && valid == 4'b0100 && opcode == LWG) lw_hold++;
            if (done) begin
                if (done_exp == 0) fail_now("unexpected_done");
                else done_exp--;
                chk("done_ready_idle", 32'(prev_ready), 32'(4'hF));
                chk("done_busy_low", 32'(busy), 32'd0);
            end
            if (err) begin
                if (err_exp == 0) fail_now("unexpected_err");
                else err_exp--;
                chk("err_busy_low", 32'(busy), 32'd0);
                chk("err_no_valid", 32'(valid), 32'd0);
            end
            prev_valid = valid;
            prev_ready = ready;
            prev_ok = 1'b1;
        end
    end

    // Ready driver, changed just after the active edge.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: ready = 4'($urandom);
            2: begin
                if (opcode == LWG && valid[2] && stall_n < 4) begin
                    ready = 4'b1011;
                    stall_n++;
                end else ready = '1;
            end
            3: begin
                if (conv_retired && drop_n < 3) begin
                    ready = '0;
                    drop_n++;
                end else ready = '1;
            end
            default: ready = '1;
        endcase
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) fail_now("timeout_wait_idle");
    endtask

    task automatic start_seq(input logic [CW-1:0] ci, input logic [PW-1:0] n, input logic acc);
        wait_idle(2000);
        @(posedge clk);
        #2;
        start = 1'b1;
        conv_in = ci;
        np_in = n;
        acc_in = acc;
        if (ci[8:6] == 0 || ci[5:3] == 0 || ci[2:0] == 0 || n == 0) err_exp++;
        else begin
            done_exp++;
            push_prog(ci, n, acc);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        conv_in = 9'($urandom);
        np_in = 8'($urandom);
    endtask

    task automatic poke_busy();
        if (busy === 1'b1) begin
            start = 1'b1;
            conv_in = 9'($urandom);
            np_in = 8'($urandom);
            acc_in = 1'($urandom);
            @(posedge clk);
            #2;
            start = 1'b0;
        end
    endtask

    task automatic run_to_done(input int budget, input logic pokes);
        int n = 0;
        while ((busy !== 1'b0 || done_exp != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
            if (pokes && ($urandom % 6) == 0) poke_busy();
        end
        if (busy !== 1'b0 || done_exp != 0) fail_now("timeout_done");
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NP; i++) expq[i].delete();
        done_exp = 0;
        err_exp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_pass", 32'(pass_idx), 32'd0);
        chk("rst_conv", 32'(conv_out), 32'd0);
    endtask

    initial begin
        logic [CW-1:0] ci;
        logic [PW-1:0] n;
        int guard;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        mode = 0;
        start_seq(9'b110_100_011, 8'd2, 1'b1);
        run_to_done(200, 1'b0);

        mode = 2;
        stall_n = 0;
        lw_hold = 0;
        start_seq(9'b110_100_011, 8'd2, 1'b1);
        run_to_done(200, 1'b0);
        chk("pe2_stall_cycles", 32'(lw_hold), 32'd4);
`ifdef PE_SEQ_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif

        mode = 0;
        start_seq(9'b110_100_000, 8'd2, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("badcfg_busy", 32'(busy), 32'd0);
            chk("badcfg_valid", 32'(valid), 32'd0);
        end
        start_seq(9'b000_100_001, 8'd1, 1'b0);
        start_seq(9'b001_001_001, 8'd0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("err_tokens", 32'(err_exp), 32'd0);

        mode = 3;
        drop_n = 0;
        conv_retired = 1'b0;
        start_seq(9'b010_010_010, 8'd1, 1'b0);
        run_to_done(200, 1'b0);
        chk("drop_cycles", 32'(drop_n), 32'd3);

        mode = 1;
        start_seq(9'b011_101_111, 8'd3, 1'b1);
        guard = 0;
        while (opcode !== CONV && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (opcode !== CONV) fail_now("timeout_conv");
        do_reset();
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("post_rst_valid", 32'(valid), 32'd0);
        end
        start_seq(9'b011_101_111, 8'd2, 1'b0);
        run_to_done(500, 1'b1);

        mode = 0;
        start_seq(9'b001_001_001, 8'd255, 1'b1);
        run_to_done(2000, 1'b1);

        for (int k = 0; k < 25; k++) begin
            mode = 1 - (($urandom % 4) == 0 ? 1 : 0);
            ci = 9'($urandom);
            if (($urandom % 5) != 0) ci = ci | 9'b001_001_001;
            n = 8'($urandom_range(0, 4));
            start_seq(ci, n, 1'($urandom));
            run_to_done(1000, 1'b1);
        end

        repeat (4) @(posedge clk);
        #2;
        for (int i = 0; i < NP; i++) chk($sformatf("leftover_pe%0d", i), 32'(expq[i].size()), 32'd0);
        chk("done_tokens_left", 32'(done_exp), 32'd0);
        chk("err_tokens_left", 32'(err_exp), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
